// File: rtl/vec_lsu_pkg.sv
// Shared types and constants for the vector load/store unit.
package vec_lsu_pkg;

    localparam int VEC_BEATS = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT1 = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/vec_lsu.sv
// Load/store unit: scalar accesses pass straight through; 128-bit vector
// accesses are split into two 64-bit memory beats with one stall cycle.
module vec_lsu
    import vec_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int VEC_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_vec,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              stall,
    output logic [VEC_W-1:0]  rdata,
    output logic              rdata_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_writeEn,
    input  logic [DATA_W-1:0] mem_readData
);

    if (VEC_W != VEC_BEATS * DATA_W) begin : g_bad_vec_w
        $error("vec_lsu: VEC_W must equal 2*DATA_W");
    end

    lsu_state_t        state_q, state_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d       = state_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        addr_d        = addr_q;
        wr_d          = wr_q;
        stall         = 1'b0;
        rdata         = '0;
        rdata_valid   = 1'b0;
        mem_address   = req_addr;
        mem_writeData = req_wdata[DATA_W-1:0];
        mem_writeEn   = 1'b0;

        if (state_q == BEAT1) begin
            // Second beat runs purely from latched state; req_* may already be changing.
            mem_address   = addr_q;
            mem_writeData = hi_q;
            mem_writeEn   = wr_q;
            if (!wr_q) begin
                rdata       = {mem_readData, lo_q};
                rdata_valid = 1'b1;
            end
            state_d = IDLE;
        end else if (req_valid) begin
            mem_writeEn = req_write;
            if (req_vec) begin
                stall   = 1'b1;
                lo_d    = mem_readData;
                hi_d    = req_wdata[VEC_W-1:DATA_W];
                addr_d  = req_addr + ADDR_W'(1);
                wr_d    = req_write;
                state_d = BEAT1;
            end else if (!req_write) begin
                rdata       = {{(VEC_W-DATA_W){1'b0}}, mem_readData};
                rdata_valid = 1'b1;
            end
        end

        if (rst) begin
            stall         = 1'b0;
            rdata         = '0;
            rdata_valid   = 1'b0;
            mem_address   = '0;
            mem_writeData = '0;
            mem_writeEn   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

endmodule

// File: tb/tb_vec_lsu.sv
// Directed bench for vec_lsu with a combinational-read memory model.
module tb_vec_lsu;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_write;
    logic          req_vec;
    logic [9:0]    req_addr;
    logic [127:0]  req_wdata;
    logic          stall;
    logic [127:0]  rdata;
    logic          rdata_valid;
    logic [9:0]    mem_address;
    logic [63:0]   mem_writeData;
    logic          mem_writeEn;
    logic [63:0]   mem_readData;

    logic [63:0]   mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_readData = mem[mem_address];

    always @(posedge clk) begin
        if (mem_writeEn) mem[mem_address] <= mem_writeData;
    end

    vec_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_vec       (req_vec),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_writeEn   (mem_writeEn),
        .mem_readData  (mem_readData)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h040] = 64'h4040_4040_0000_0040;
        mem[10'h041] = 64'h4141_4141_0000_0041;
        mem[10'h100] = 64'h0100_0100_0100_0100;
        mem[10'h051] = 64'h5151_5151_5151_5151;
        mem[10'h060] = 64'h6060_0000_0000_0060;
        mem[10'h061] = 64'h6161_0000_0000_0061;
        mem[10'h062] = 64'h6262_0000_0000_0062;
        mem[10'h063] = 64'h6363_0000_0000_0063;

        // Reset forces outputs even with an active vector store on the inputs.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b1;
        req_addr  = 10'h123;
        req_wdata = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        settle();
        check("rst_stall",   128'(stall),       128'd0);
        check("rst_wen",     128'(mem_writeEn), 128'd0);
        check("rst_valid",   128'(rdata_valid), 128'd0);
        check("rst_rdata",   rdata,             128'd0);
        check("rst_addr",    128'(mem_address), 128'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // 1. Scalar store then scalar load.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b0;
        req_addr  = 10'h010;
        req_wdata = {64'h5555_5555_5555_5555, 64'hDEAD_BEEF_CAFE_F00D};
        settle();
        check("s_st_stall", 128'(stall),         128'd0);
        check("s_st_wen",   128'(mem_writeEn),   128'd1);
        check("s_st_addr",  128'(mem_address),   128'h010);
        check("s_st_wdata", 128'(mem_writeData), 128'hDEAD_BEEF_CAFE_F00D);
        check("s_st_valid", 128'(rdata_valid),   128'd0);
        next_cycle();
        req_write = 1'b0;
        settle();
        check("s_ld_stall", 128'(stall),       128'd0);
        check("s_ld_wen",   128'(mem_writeEn), 128'd0);
        check("s_ld_valid", 128'(rdata_valid), 128'd1);
        check("s_ld_rdata", rdata,             128'h0000_0000_0000_0000_DEAD_BEEF_CAFE_F00D);
        next_cycle();

        // 2. Vector store then vector load at 0x020.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b1;
        req_addr  = 10'h020;
        req_wdata = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        settle();
        check("v_st_b0_stall", 128'(stall),         128'd1);
        check("v_st_b0_wen",   128'(mem_writeEn),   128'd1);
        check("v_st_b0_addr",  128'(mem_address),   128'h020);
        check("v_st_b0_wdata", 128'(mem_writeData), 128'h8899_AABB_CCDD_EEFF);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("v_st_b1_stall", 128'(stall),         128'd0);
        check("v_st_b1_wen",   128'(mem_writeEn),   128'd1);
        check("v_st_b1_addr",  128'(mem_address),   128'h021);
        check("v_st_b1_wdata", 128'(mem_writeData), 128'h0011_2233_4455_6677);
        check("v_st_b1_valid", 128'(rdata_valid),   128'd0);
        next_cycle();
        check("v_st_mem020", 128'(mem[10'h020]), 128'h8899_AABB_CCDD_EEFF);
        check("v_st_mem021", 128'(mem[10'h021]), 128'h0011_2233_4455_6677);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_vec   = 1'b1;
        req_addr  = 10'h020;
        settle();
        check("v_ld_b0_stall", 128'(stall),       128'd1);
        check("v_ld_b0_valid", 128'(rdata_valid), 128'd0);
        check("v_ld_b0_rdata", rdata,             128'd0);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("v_ld_b1_stall", 128'(stall),       128'd0);
        check("v_ld_b1_valid", 128'(rdata_valid), 128'd1);
        check("v_ld_b1_rdata", rdata,             128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        next_cycle();

        // 3. Vector store wrapping from 0x3FF to 0x000.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b1;
        req_addr  = 10'h3FF;
        req_wdata = {64'h2, 64'h1};
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("wrap_b1_addr", 128'(mem_address), 128'h000);
        next_cycle();
        check("wrap_mem3ff", 128'(mem[10'h3FF]), 128'h1);
        check("wrap_mem000", 128'(mem[10'h000]), 128'h2);

        // 4. Inputs change during the stall; beat 1 must ignore them.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_vec   = 1'b1;
        req_addr  = 10'h040;
        next_cycle();
        req_addr  = 10'h100;
        req_write = 1'b1;
        settle();
        check("chg_b1_addr",  128'(mem_address), 128'h041);
        check("chg_b1_wen",   128'(mem_writeEn),  128'd0);
        check("chg_b1_rdata", rdata,              128'h4141_4141_0000_0041_4040_4040_0000_0040);
        next_cycle();
        req_valid = 1'b0;
        req_write = 1'b0;
        check("chg_mem100", 128'(mem[10'h100]), 128'h0100_0100_0100_0100);
        check("chg_mem041", 128'(mem[10'h041]), 128'h4141_4141_0000_0041);

        // 5. Reset during beat 1 of a vector store at 0x050.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_vec   = 1'b1;
        req_addr  = 10'h050;
        req_wdata = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        next_cycle();
        rst = 1'b1;
        settle();
        check("rstb1_wen",   128'(mem_writeEn), 128'd0);
        check("rstb1_stall", 128'(stall),       128'd0);
        check("rstb1_addr",  128'(mem_address), 128'd0);
        next_cycle();
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = 10'h077;
        settle();
        check("rstb1_idle_stall", 128'(stall),       128'd0);
        check("rstb1_idle_addr",  128'(mem_address), 128'h077);
        check("rstb1_idle_wen",   128'(mem_writeEn), 128'd0);
        check("rstb1_mem050", 128'(mem[10'h050]), 128'hAAAA_AAAA_AAAA_AAAA);
        check("rstb1_mem051", 128'(mem[10'h051]), 128'h5151_5151_5151_5151);
        next_cycle();

        // 6. Back-to-back vector loads at 0x060 then 0x062.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_vec   = 1'b1;
        req_addr  = 10'h060;
        settle();
        check("b2b_c0_stall", 128'(stall),       128'd1);
        check("b2b_c0_valid", 128'(rdata_valid), 128'd0);
        next_cycle();
        req_addr = 10'h062;
        settle();
        check("b2b_c1_stall", 128'(stall),       128'd0);
        check("b2b_c1_valid", 128'(rdata_valid), 128'd1);
        check("b2b_c1_rdata", rdata,             128'h6161_0000_0000_0061_6060_0000_0000_0060);
        next_cycle();
        settle();
        check("b2b_c2_stall", 128'(stall),       128'd1);
        check("b2b_c2_valid", 128'(rdata_valid), 128'd0);
        check("b2b_c2_addr",  128'(mem_address), 128'h062);
        next_cycle();
        req_valid = 1'b0;
        settle();
        check("b2b_c3_stall", 128'(stall),       128'd0);
        check("b2b_c3_valid", 128'(rdata_valid), 128'd1);
        check("b2b_c3_rdata", rdata,             128'h6363_0000_0000_0063_6262_0000_0000_0062);
        next_cycle();
        settle();
        check("idle_valid", 128'(rdata_valid), 128'd0);
        check("idle_rdata", rdata,             128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
